// File: rtl/fab_clk_tick_gen.sv
// -----------------------------------------------------------------------------
// fab_clk_tick_gen
// Fabric timebase for the turret blocks. Runs on FAB_CLK only. It synchronises
// reset, holds the fabric in reset for a startup window, then emits a 1-cycle
// microsecond tick (TICK_1US) and a servo-frame tick (FRAME_TICK). Downstream
// blocks use these as clock enables, never as derived clocks.
//
// Ports
//   FAB_CLK       in   fabric clock from the CCC
//   MSS_RESET_N   in   asynchronous active-low reset
//   FAB_LOCK      in   CCC lock, asynchronous to FAB_CLK (used only with the
//                      lock gate built in)
//   TICK_CLR      in   synchronous restart of prescaler and frame counter (RUN only)
//   RESET_N_SYNC  out  fabric reset: asserts asynchronously, releases in RUN
//   READY         out  high in RUN
//   TICK_1US      out  one-cycle pulse every DIV cycles in RUN
//   FRAME_TICK    out  one-cycle pulse on the tick that wraps FRAME_CNT
//   FRAME_CNT     out  ticks elapsed in the current frame
//
// Build option
//   FAB_LOCK_GATE_EN  when defined, FAB_LOCK is synchronised (2 flops) and loss
//                     of lock forces the block back to WAIT_LOCK. When not
//                     defined, lock is treated as always good (CCC bypass,
//                     where the lock pin is tied low).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fab_clk_tick_gen #(
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned TICK_HZ        = 1_000_000,
   parameter int unsigned STARTUP_CYCLES = 1024,
   parameter int unsigned FRAME_TICKS    = 20000
) (
   input  logic        FAB_CLK,
   input  logic        MSS_RESET_N,
   input  logic        FAB_LOCK,
   input  logic        TICK_CLR,
   output logic        RESET_N_SYNC,
   output logic        READY,
   output logic        TICK_1US,
   output logic        FRAME_TICK,
   output logic [14:0] FRAME_CNT
);

   // state     | meaning
   // WAIT_LOCK | waiting for synchronised reset release and good lock
   // HOLD      | startup window, hold_cnt counts 0..STARTUP_CYCLES-1
   // RUN       | fabric out of reset, prescaler and frame counter active

   localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
   localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned HOLD_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

   localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(DIV - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(STARTUP_CYCLES - 1);
   localparam logic [14:0]       FRAME_LAST = 15'(FRAME_TICKS - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [14:0]       frame_cnt_q, frame_cnt_d;
   logic              tick_q, tick_d;
   logic              frame_tick_q, frame_tick_d;
   logic              run_q, run_d;
   logic              rst_meta_q, rst_s_q;
   logic              lock_ok;

   // Reset synchroniser: cleared asynchronously, releases on the 2nd edge.
   always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         rst_meta_q <= 1'b0;
         rst_s_q    <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_s_q    <= rst_meta_q;
      end
   end

`ifdef FAB_LOCK_GATE_EN
   logic lock_meta_q, lock_ok_q;

   always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         lock_meta_q <= 1'b0;
         lock_ok_q   <= 1'b0;
      end else begin
         lock_meta_q <= FAB_LOCK;
         lock_ok_q   <= lock_meta_q;
      end
   end

   assign lock_ok = lock_ok_q;
`else
   // Lock pin is meaningless in CCC bypass; keep it connected but ignored.
   logic unused_fab_lock;
   assign unused_fab_lock = FAB_LOCK;
   assign lock_ok         = 1'b1;
`endif

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      pre_d        = pre_q;
      frame_cnt_d  = frame_cnt_q;
      tick_d       = 1'b0;
      frame_tick_d = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            hold_cnt_d  = '0;
            pre_d       = '0;
            frame_cnt_d = '0;
            if (rst_s_q && lock_ok) begin
               state_d = HOLD;
            end
         end

         HOLD: begin
            pre_d       = '0;
            frame_cnt_d = '0;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = RUN;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end

         RUN: begin
            // Priority: lock loss, then TICK_CLR, then terminal count.
            if (!lock_ok) begin
               state_d     = WAIT_LOCK;
               hold_cnt_d  = '0;
               pre_d       = '0;
               frame_cnt_d = '0;
            end else if (TICK_CLR) begin
               pre_d       = '0;
               frame_cnt_d = '0;
            end else if (pre_q == PRE_LAST) begin
               pre_d  = '0;
               tick_d = 1'b1;
               if (frame_cnt_q == FRAME_LAST) begin
                  frame_cnt_d  = '0;
                  frame_tick_d = 1'b1;
               end else begin
                  frame_cnt_d = frame_cnt_q + 15'd1;
               end
            end else begin
               pre_d = pre_q + PRE_W'(1);
            end
         end

         default: begin
            state_d     = WAIT_LOCK;
            hold_cnt_d  = '0;
            pre_d       = '0;
            frame_cnt_d = '0;
         end
      endcase

      // Registered from the next state so READY tracks RUN cycle-exactly.
      run_d = (state_d == RUN);
   end

   always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
      if (!MSS_RESET_N) begin
         state_q      <= WAIT_LOCK;
         hold_cnt_q   <= '0;
         pre_q        <= '0;
         frame_cnt_q  <= '0;
         tick_q       <= 1'b0;
         frame_tick_q <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         pre_q        <= pre_d;
         frame_cnt_q  <= frame_cnt_d;
         tick_q       <= tick_d;
         frame_tick_q <= frame_tick_d;
         run_q        <= run_d;
      end
   end

   assign RESET_N_SYNC = run_q;
   assign READY        = run_q;
   assign TICK_1US     = tick_q;
   assign FRAME_TICK   = frame_tick_q;
   assign FRAME_CNT    = frame_cnt_q;

endmodule

// File: tb/tb_fab_clk_tick_gen.sv
`timescale 1ns/1ps

module tb_fab_clk_tick_gen;

   logic FAB_CLK = 1'b0;
   always #5 FAB_CLK = ~FAB_CLK;

   // default-parameter instance
   logic        mss_reset_n, fab_lock, tick_clr;
   logic        rst_n_sync, ready, tick_1us, frame_tick;
   logic [14:0] frame_cnt;

   // small instance: DIV=2, FRAME_TICKS=4, STARTUP_CYCLES=4
   logic        fast_reset_n, fast_lock, fast_clr;
   logic        fast_rst_n_sync, fast_ready, fast_tick, fast_ftick;
   logic [14:0] fast_fcnt;

   fab_clk_tick_gen u_dut (
      .FAB_CLK      (FAB_CLK),
      .MSS_RESET_N  (mss_reset_n),
      .FAB_LOCK     (fab_lock),
      .TICK_CLR     (tick_clr),
      .RESET_N_SYNC (rst_n_sync),
      .READY        (ready),
      .TICK_1US     (tick_1us),
      .FRAME_TICK   (frame_tick),
      .FRAME_CNT    (frame_cnt)
   );

   fab_clk_tick_gen #(
      .CLK_HZ         (2),
      .TICK_HZ        (1),
      .STARTUP_CYCLES (4),
      .FRAME_TICKS    (4)
   ) u_fast (
      .FAB_CLK      (FAB_CLK),
      .MSS_RESET_N  (fast_reset_n),
      .FAB_LOCK     (fast_lock),
      .TICK_CLR     (fast_clr),
      .RESET_N_SYNC (fast_rst_n_sync),
      .READY        (fast_ready),
      .TICK_1US     (fast_tick),
      .FRAME_TICK   (fast_ftick),
      .FRAME_CNT    (fast_fcnt)
   );

   integer errors = 0;
   integer checks = 0;
   integer n, early, nt, nr;
   integer tpos [3];

   task automatic check(input string tag, input integer got, input integer exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge FAB_CLK);
      #1;
   endtask

   // Cycles from now until READY rises on the default instance (-1 on timeout);
   // early flags any nonzero output seen before that.
   task automatic wait_def_ready(output integer cyc, output integer quiet_err);
      cyc       = -1;
      quiet_err = 0;
      for (int k = 1; k <= 2000 && cyc < 0; k++) begin
         step();
         if (ready === 1'b1) cyc = k;
         else if (rst_n_sync !== 1'b0 || tick_1us !== 1'b0 || frame_tick !== 1'b0 ||
                  frame_cnt !== 15'd0)
            quiet_err = 1;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      mss_reset_n  = 1'b0;
      fab_lock     = 1'b1;
      tick_clr     = 1'b0;
      fast_reset_n = 1'b0;
      fast_lock    = 1'b1;
      fast_clr     = 1'b0;
      repeat (3) step();

      // reset state
      check("rst_ready",  ready,      0);
      check("rst_rstn",   rst_n_sync, 0);
      check("rst_tick",   tick_1us,   0);
      check("rst_ftick",  frame_tick, 0);
      check("rst_fcnt",   frame_cnt,  0);

      // reset release: 2 sync + 1024 hold + 1
      mss_reset_n = 1'b1;
      wait_def_ready(n, early);
      check("rel_latency", n, 1027);
      check("rel_quiet",   early, 0);
      check("rel_rstn",    rst_n_sync, 1);

      // tick cadence: now at RUN cycle 0
      nt = 0;
      for (int i = 0; i < 3; i++) tpos[i] = -1;
      for (int c = 1; c <= 300; c++) begin
         step();
         if (tick_1us === 1'b1) begin
            if (nt < 3) tpos[nt] = c;
            nt++;
         end
      end
      check("tick_count", nt, 3);
      check("tick_pos0",  tpos[0], 100);
      check("tick_pos1",  tpos[1], 200);
      check("tick_pos2",  tpos[2], 300);
      step();
      check("tick_width", tick_1us,   0);
      check("fcnt_301",   frame_cnt,  3);
      check("ftick_none", frame_tick, 0);

      // frame wrap on small instance
      fast_reset_n = 1'b1;
      n = -1;
      for (int k = 1; k <= 50 && n < 0; k++) begin
         step();
         if (fast_ready === 1'b1) n = k;
      end
      check("fast_latency", n, 7);
      for (int c = 1; c <= 16; c++) begin
         step();
         check($sformatf("wrap_fcnt_c%0d", c),  fast_fcnt,  (c / 2) % 4);
         check($sformatf("wrap_tick_c%0d", c),  fast_tick,  (c % 2 == 0) ? 1 : 0);
         check($sformatf("wrap_ftick_c%0d", c), fast_ftick, (c % 8 == 0) ? 1 : 0);
      end

      // TICK_CLR on terminal-count cycle (cycle 23: pre=1, FRAME_CNT=3)
      repeat (7) step();
      check("clr_pre_fcnt", fast_fcnt, 3);
      check("clr_pre_tick", fast_tick, 0);
      fast_clr = 1'b1;
      step();
      fast_clr = 1'b0;
      check("clr_tick",  fast_tick,  0);
      check("clr_ftick", fast_ftick, 0);
      check("clr_fcnt",  fast_fcnt,  0);
      step();
      check("clr_tick_c1", fast_tick, 0);
      step();
      check("clr_tick_c2", fast_tick, 1);
      check("clr_fcnt_c2", fast_fcnt, 1);

`ifdef FAB_LOCK_GATE_EN
      // lock loss in RUN
      fab_lock = 1'b0;
      n = -1;
      for (int k = 1; k <= 10 && n < 0; k++) begin
         step();
         if (ready === 1'b0) n = k;
      end
      check("lock_drop_latency", n, 3);
      check("lock_drop_rstn", rst_n_sync, 0);
      nt = 0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (tick_1us !== 1'b0 || ready !== 1'b0) nt++;
      end
      check("lock_quiet", nt, 0);
      check("lock_fcnt",  frame_cnt, 0);
      fab_lock = 1'b1;
      wait_def_ready(n, early);
      check("relock_latency", n, 1027);
      check("relock_quiet",   early, 0);
`else
      // lock pin ignored in this build
      fab_lock = 1'b0;
      nt = 0;
      nr = 0;
      for (int c = 0; c < 200; c++) begin
         step();
         if (tick_1us === 1'b1) nt++;
         if (ready !== 1'b1) nr++;
      end
      check("nolock_ready_drop", nr, 0);
      check("nolock_ticks",      nt, 2);
      fab_lock = 1'b1;
`endif

      // async reset mid-frame, between clock edges
      repeat (250) step();
      check("mid_fcnt_nonzero", (frame_cnt != 15'd0) ? 1 : 0, 1);
      #2;
      mss_reset_n  = 1'b0;
      fast_reset_n = 1'b0;
      #1;
      check("async_ready",  ready,      0);
      check("async_rstn",   rst_n_sync, 0);
      check("async_tick",   tick_1us,   0);
      check("async_ftick",  frame_tick, 0);
      check("async_fcnt",   frame_cnt,  0);
      check("async_fready", fast_ready, 0);
      check("async_ffcnt",  fast_fcnt,  0);
      repeat (3) step();
      mss_reset_n = 1'b1;
      wait_def_ready(n, early);
      check("rerel_latency", n, 1027);
      check("rerel_quiet",   early, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
